// File: rtl/muldiv_ctrl.sv
// Iterative RV32M multiply/divide unit for the EX stage: one bit per cycle,
// with stall and result handshakes back to the in-order pipeline.
module muldiv_ctrl #(
   parameter bit FAST_SPECIAL = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_EX_I,
   input  logic [2:0]  md_op_EX_I,
   input  logic [31:0] Rd_data1_EX_I,
   input  logic [31:0] Rd_data2_EX_I,
   input  logic        flush_EX_I,
   output logic        stall_EX_O,
   output logic        md_done_EX_O,
   output logic [31:0] md_result_EX_O
);

   // state | meaning
   // IDLE  | waiting for an M-extension op in EX
   // BUSY  | iterating, counter 0..31
   // DONE  | result presented for one cycle
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [2:0]  op;
   logic [31:0] hi, lo, m, a_raw;
   logic        neg_res, div0, ovf;

   logic        a_sgn, b_sgn, neg_in, is_div, div0_in, ovf_in;
   logic [31:0] mag_a, mag_b;

   always_comb begin
      is_div  = md_op_EX_I[2];
      a_sgn   = Rd_data1_EX_I[31] & (md_op_EX_I == 3'd1 || md_op_EX_I == 3'd2 ||
                                     md_op_EX_I == 3'd4 || md_op_EX_I == 3'd6);
      b_sgn   = Rd_data2_EX_I[31] & (md_op_EX_I == 3'd1 || md_op_EX_I == 3'd4 ||
                                     md_op_EX_I == 3'd6);
      mag_a   = a_sgn ? (32'd0 - Rd_data1_EX_I) : Rd_data1_EX_I;
      mag_b   = b_sgn ? (32'd0 - Rd_data2_EX_I) : Rd_data2_EX_I;
      neg_in  = (md_op_EX_I == 3'd6) ? a_sgn : (a_sgn ^ b_sgn);
      div0_in = is_div & (Rd_data2_EX_I == 32'd0);
      ovf_in  = is_div & ~md_op_EX_I[0] & (Rd_data1_EX_I == 32'h8000_0000) &
                (Rd_data2_EX_I == 32'hFFFF_FFFF);
   end

   // One iteration step. Multiply: hi accumulates, lo shifts out multiplier
   // bits and collects product low bits. Divide: hi is the partial remainder,
   // lo shifts out dividend bits and collects quotient bits.
   logic [32:0] mul_sum;
   logic [32:0] div_sh;
   logic [31:0] div_sub;
   logic        div_ok;

   always_comb begin
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : 33'd0);
      div_sh  = {hi, lo[31]};
      div_ok  = (div_sh >= {1'b0, m});
      div_sub = div_sh[31:0] - m;
   end

   logic [63:0] prod_s;
   logic [31:0] quo_s, rem_s, res;

   always_comb begin
      prod_s = neg_res ? (64'd0 - {hi, lo}) : {hi, lo};
      quo_s  = neg_res ? (32'd0 - lo) : lo;
      rem_s  = neg_res ? (32'd0 - hi) : hi;
      res    = 32'd0;
      case (op)
         3'd0:                res = prod_s[31:0];
         3'd1, 3'd2, 3'd3:    res = prod_s[63:32];
         3'd4, 3'd5:          res = div0 ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : quo_s);
         default:             res = div0 ? a_raw : (ovf ? 32'd0 : rem_s);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 5'd0;
         op      <= 3'd0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         m       <= 32'd0;
         a_raw   <= 32'd0;
         neg_res <= 1'b0;
         div0    <= 1'b0;
         ovf     <= 1'b0;
      end else if (flush_EX_I) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (valid_EX_I) begin
               op      <= md_op_EX_I;
               cnt     <= 5'd0;
               hi      <= 32'd0;
               lo      <= is_div ? mag_a : mag_b;
               m       <= is_div ? mag_b : mag_a;
               a_raw   <= Rd_data1_EX_I;
               neg_res <= neg_in;
               div0    <= div0_in;
               ovf     <= ovf_in;
               state   <= ((div0_in || ovf_in) && FAST_SPECIAL) ? DONE : BUSY;
            end
            BUSY: begin
               if (op[2]) begin
                  hi <= div_ok ? div_sub : div_sh[31:0];
                  lo <= {lo[30:0], div_ok};
               end else begin
                  hi <= mul_sum[32:1];
                  lo <= {mul_sum[0], lo[31:1]};
               end
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign stall_EX_O     = ~flush_EX_I & (((state == IDLE) & valid_EX_I) | (state == BUSY));
   assign md_done_EX_O   = (state == DONE);
   assign md_result_EX_O = (state == DONE) ? res : 32'd0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, stall length, results, flush and reset abort.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [2:0]  md_op;
   logic [31:0] a, b;
   logic        flush;
   logic        stall, md_done;
   logic [31:0] md_result;

   int checks = 0;
   int errors = 0;
   time t_done;

   muldiv_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .valid_EX_I     (valid),
      .md_op_EX_I     (md_op),
      .Rd_data1_EX_I  (a),
      .Rd_data2_EX_I  (b),
      .flush_EX_I     (flush),
      .stall_EX_O     (stall),
      .md_done_EX_O   (md_done),
      .md_result_EX_O (md_result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called just after a rising edge; leaves valid high so ops run back to back.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int exp_cyc);
      int cyc = 0;
      int stall_cnt = 0;
      bit got = 0;
      valid = 1'b1;
      md_op = o;
      a = x;
      b = y;
      while (cyc < 100 && !got) begin
         @(negedge clk);
         if (md_done) got = 1;
         else begin
            if (stall) stall_cnt++;
            @(posedge clk);
            #1;
            if (cyc == 0) begin
               a = $urandom;
               b = $urandom;
            end
            cyc++;
         end
      end
      chk({tag, "_done"}, 64'(got), 64'd1);
      chk({tag, "_lat"}, 64'(cyc), 64'(exp_cyc));
      chk({tag, "_stall_len"}, 64'(stall_cnt), 64'(exp_cyc));
      chk({tag, "_result"}, 64'(md_result), 64'(exp));
      chk({tag, "_stall_in_done"}, 64'(stall), 64'd0);
      t_done = $time;
      @(posedge clk);
      #1;
   endtask

   task automatic count_done(input string tag, input int n);
      int pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (md_done) pulses++;
      end
      chk(tag, 64'(pulses), 64'd0);
   endtask

   initial begin
      time t1;
      rst = 1'b1; valid = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0; flush = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_done", 64'(md_done), 64'd0);
      chk("rst_result", 64'(md_result), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      run_op("mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_op("mulhu_ones",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mulh_ones",    3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33);
      run_op("mulhsu_m1_2",  3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);
      run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
      run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
      run_op("rem_7_m2",     3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33);
      run_op("divu_100_7",   3'd5, 32'd100,        32'd7,         32'd14,        33);
      run_op("remu_100_7",   3'd7, 32'd100,        32'd7,         32'd2,         33);
      run_op("mul_zero",     3'd0, 32'd0,          32'd5,         32'd0,         33);
      run_op("divu_5_0",     3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
      run_op("remu_5_0",     3'd7, 32'd5,          32'd0,         32'd5,         1);
      run_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

      // Flush while the counter reads 10.
      valid = 1'b1; md_op = 3'd0; a = 32'd7; b = 32'd9;
      repeat (11) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      @(negedge clk);
      chk("flush_stall_drop", 64'(stall), 64'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      valid = 1'b0;
      @(negedge clk);
      chk("flush_idle_stall", 64'(stall), 64'd0);
      count_done("flush_no_done", 40);
      @(posedge clk);
      #1;
      run_op("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, 33);

      // Reset while the counter reads 20.
      md_op = 3'd5; a = 32'd1000; b = 32'd3;
      repeat (21) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstbusy_stall", 64'(stall), 64'd0);
      chk("rstbusy_done", 64'(md_done), 64'd0);
      chk("rstbusy_result", 64'(md_result), 64'd0);
      count_done("rstbusy_no_done", 40);
      @(posedge clk);
      #1;

      run_op("b2b_divu_a", 3'd5, 32'd50, 32'd6, 32'd8, 33);
      t1 = t_done;
      run_op("b2b_divu_b", 3'd5, 32'd81, 32'd9, 32'd9, 33);
      chk("b2b_gap", 64'(t_done - t1), 64'd340);
      valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter FAST_SPECIAL, default 1; when 1, divide-by-zero and signed-overflow divides complete without iterating.
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port valid_EX_I, input, 1, the EX instruction is an M-extension op.
REQ-005 SHALL have port md_op_EX_I, input, 3, funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have ports Rd_data1_EX_I and Rd_data2_EX_I, input, 32 each, operands A and B.
REQ-007 SHALL have port flush_EX_I, input, 1, kills the EX instruction, e.g. on a taken branch or jump ahead of it.
REQ-008 SHALL have port stall_EX_O, output, 1, freezes PC, IF/ID and ID/EX while high.
REQ-009 SHALL have port md_done_EX_O, output, 1, result valid this cycle.
REQ-010 SHALL have port md_result_EX_O, output, 32, result selected over ALU_result by the EX result mux when md_done_EX_O is high.

Function
REQ-011 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-012 IDLE, when valid_EX_I=1 and flush_EX_I=0: SHALL latch the op and both operands, and SHALL clear the 5-bit iteration counter.
- If the op is a special case and FAST_SPECIAL=1, next state SHALL be DONE.
- Otherwise, next state SHALL be BUSY.
REQ-013 Special cases: divisor 0, or a signed op (4 or 6) with A=0x80000000 and B=0xFFFFFFFF.
REQ-014 BUSY SHALL process one bit per cycle; the counter runs 0..31 and SHALL go to DONE on the cycle the counter equals 31.
- Multiply: shift-add on operand magnitudes into a 64-bit product.
- Divide: restoring division on magnitudes producing 32-bit quotient and remainder.
REQ-015 Sign handling: SHALL convert signed operands to magnitude before iterating and SHALL negate the result in DONE where required.
- MULH: both operands signed.
- MULHSU: A signed, B unsigned.
- DIV: quotient negative iff the operand signs differ.
- REM: remainder takes the sign of A.
REQ-016 Results SHALL be:
- MUL: product[31:0].
- MULH, MULHSU, MULHU: product[63:32].
- DIV, DIVU: quotient.
- REM, REMU: remainder.
REQ-017 Divide by 0 SHALL give quotient 0xFFFFFFFF and remainder equal to A. Signed overflow SHALL give quotient 0x80000000 and remainder 0.
REQ-018 DONE SHALL hold md_done_EX_O=1 and md_result_EX_O valid for exactly one cycle, then return to IDLE unconditionally.
REQ-019 stall_EX_O SHALL be combinational:
- 1 when (IDLE and valid_EX_I and not flush_EX_I) or BUSY.
- 0 in DONE, so the pipeline advances at the edge ending DONE.
REQ-020 Latency: request accepted at edge k SHALL produce DONE during cycle k+33 for iterating ops and cycle k+1 for special cases; the stall lasts 33 cycles or 1 cycle respectively.
REQ-021 The instruction still presenting valid_EX_I during DONE SHALL NOT be re-accepted; a back-to-back M op is accepted in the IDLE cycle that follows.
REQ-022 flush_EX_I=1 in any state SHALL force the next state to IDLE, with no md_done_EX_O pulse, and stall_EX_O SHALL drop in that same cycle.
REQ-023 Operand changes on the inputs during BUSY SHALL be ignored; only the latched copies are used.
REQ-024 Iterations SHALL NOT terminate early for zero or small operands, except for the special cases in REQ-013.

Reset
REQ-025 rst=1 at a clock edge SHALL force:
- state IDLE and counter 0;
- md_done_EX_O=0;
- md_result_EX_O=0x00000000;
- stall_EX_O=0 in the following cycle unless a new request is present.
REQ-026 Reset mid-BUSY SHALL abort the operation, and no result SHALL be produced.

Verification
REQ-027 MUL, A=7, B=-3 (0xFFFFFFFD) -> stall 33 cycles, then DONE for one cycle with result 0xFFFFFFEB.
REQ-028 MULHU, A=B=0xFFFFFFFF -> result 0xFFFFFFFE; MULH with the same operands -> result 0x00000000.
REQ-029 DIV, A=-7, B=2 -> result 0xFFFFFFFD (-3); REM with the same operands -> result 0xFFFFFFFF (-1); DIVU, A=100, B=7 -> result 14.
REQ-030 DIVU, A=5, B=0 -> DONE one cycle after acceptance with result 0xFFFFFFFF; DIV, A=0x80000000, B=-1 -> result 0x80000000; REM with the same operands -> result 0.
REQ-031 flush_EX_I pulsed at BUSY counter 10 -> IDLE next cycle, no md_done_EX_O pulse; a following MUL 3*4 then completes with result 12.
REQ-032 rst asserted at BUSY counter 20 -> IDLE, all outputs 0; two back-to-back DIVU ops -> two done pulses 34 cycles apart.
